// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and sizing helpers for the UART word receiver.
// Optional feature macro used by the receiver: UART_RX_TIMEOUT_EN.
package uart_rx_pkg;

    // Bit-level receive FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } bit_state_t;

    // Default build: 32-bit words at 115200 baud from a 100 MHz clock.
    localparam int W_DEFAULT    = 32;
    localparam int CLKS_DEFAULT = 868;

    // Number of bytes per assembled word (NB = W/8).
    function automatic int nb_of(input int w);
        return w / 8;
    endfunction

    // Width of the bit-period down-counter ($clog2(CLKS_PER_BIT)).
    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop RX synchroniser plus 8N1 bit FSM.
// byte_valid and frame_err are single-cycle combinational pulses asserted in
// the cycle the stop bit is sampled; the word assembler registers them.
// With UART_RX_TIMEOUT_EN defined, an in_idle status output is added.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic       in_idle
`endif
);

    localparam int             CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_p0, rx_p1;
    logic            rx_s;
    bit_state_t      state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      idx, idx_nx;
    logic [7:0]      shreg, shreg_nx;
    logic            err_wait, err_wait_nx;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    // Bit FSM state register with its counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            err_wait <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            shreg    <= shreg_nx;
            err_wait <= err_wait_nx;
        end
    end

    // Next-state logic: mid-bit sampling, LSB first; after a bad stop bit,
    // park in STOP until the line returns high so the error pulses only once.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        shreg_nx    = shreg;
        err_wait_nx = err_wait;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = HALF;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        idx_nx   = 3'd0;
                        cnt_nx   = FULL;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nx = {rx_s, shreg[7:1]};
                    cnt_nx   = FULL;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STOP: begin
                if (err_wait) begin
                    if (rx_s) begin
                        err_wait_nx = 1'b0;
                        state_nx    = IDLE;
                    end
                end else if (cnt == '0) begin
                    if (rx_s) begin
                        byte_valid = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        frame_err   = 1'b1;
                        err_wait_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rx_byte = shreg;

`ifdef UART_RX_TIMEOUT_EN
    assign in_idle = (state == IDLE);
`endif

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: assembles NB = W/8 UART bytes (LSB byte first) into one word
// and offers it to the consumer with a level ready_op / ack_op handshake.
// Optional feature macro: UART_RX_TIMEOUT_EN -- discards a partial word after
// TIMEOUT_BITS idle bit periods.
module uart_rx_word
    import uart_rx_pkg::*;
#(
    parameter int W            = W_DEFAULT,
    parameter int CLKS_PER_BIT = CLKS_DEFAULT
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 20
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX,
    input  logic         ack_op,
    output logic [W-1:0] data_out,
    output logic         ready_op,
    output logic         frame_err,
    output logic         overrun
);

    localparam int NB  = nb_of(W);
    localparam int BCW = $clog2(NB);

    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           byte_ferr;
    logic [BCW-1:0] byte_cnt;
    logic [W-9:0]   part_buf;
    logic [W-1:0]   word_full;
    logic           last_byte;
    logic           word_done;
    logic           take;
    logic           timeout_hit;

`ifdef UART_RX_TIMEOUT_EN
    logic in_idle;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (byte_ferr)
`ifdef UART_RX_TIMEOUT_EN
        ,
        .in_idle   (in_idle)
`endif
    );

    assign last_byte = (byte_cnt == BCW'(NB - 1));
    assign word_done = byte_valid && last_byte;
    assign word_full = {rx_byte, part_buf};
    assign take      = ack_op && ready_op;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TOW      = $clog2(TO_LIMIT + 1);

    logic [TOW-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == TOW'(TO_LIMIT));

    // Idle timer: counts only while a partial word waits and the line is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (!in_idle || byte_cnt == '0 || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Byte assembler: bytes 0..NB-2 are buffered; the last one completes the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            part_buf <= '0;
        end else if (byte_ferr || timeout_hit) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            if (last_byte) begin
                byte_cnt <= '0;
            end else begin
                part_buf[8*byte_cnt +: 8] <= rx_byte;
                byte_cnt                  <= byte_cnt + 1'b1;
            end
        end
    end

    // Output handshake: a finished word loads unless an unacked word is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            ready_op <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (take) begin
                overrun <= 1'b0;
            end
            if (word_done) begin
                if (!ready_op || take) begin
                    data_out <= word_full;
                    ready_op <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (take) begin
                ready_op <= 1'b0;
            end
        end
    end

    // Frame error flag: one-cycle registered copy of the bit FSM's pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= byte_ferr;
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: vector table plus hand-written corner sequences for the
// UART word receiver (W=32, CLKS_PER_BIT=16). Expected words go to a
// scoreboard queue when sent and are popped when ready_op presents them.
module tb_uart_rx_word;

    localparam int W   = 32;
    localparam int CPB = 16;

    logic         clk;
    logic         rst;
    logic         RX;
    logic         ack_op;
    logic [W-1:0] data_out;
    logic         ready_op;
    logic         frame_err;
    logic         overrun;

    int total = 0;
    int bad   = 0;
    int ferr_seen = 0;
    int ferr_wide = 0;
    logic ferr_prev = 1'b0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    uart_rx_word #(
        .W           (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .ack_op   (ack_op),
        .data_out (data_out),
        .ready_op (ready_op),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame error pulse monitor: counts pulses and flags any longer than 1 cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            ferr_seen = ferr_seen + 1;
            if (ferr_prev) ferr_wide = ferr_wide + 1;
        end
        ferr_prev = (frame_err === 1'b1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; ack_op is raised for the single stop-bit cycle ack_at.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int ack_at);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        for (int i = 0; i < CPB; i++) begin
            ack_op = (i == ack_at);
            @(negedge clk);
        end
        ack_op = 1'b0;
        RX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, -1);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready_op !== 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(ready_op), 64'd1);
    endtask

    task automatic check_sb(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, data_out);
        end else begin
            e = exp_q.pop_front();
            chk(name, 64'(data_out), 64'(e));
        end
    endtask

    task automatic do_ack(input string name);
        ack_op = 1'b1;
        @(negedge clk);
        ack_op = 1'b0;
        chk(name, 64'(ready_op), 64'd0);
    endtask

    initial begin
        int f0;
        vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[3] = '{8'h01, 8'h5A, 8'hA5, 8'h80, 32'h80A55A01};

        rst    = 1'b0;
        RX     = 1'b1;
        ack_op = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset data_out", 64'(data_out), 64'd0);
        chk("reset ready_op", 64'(ready_op), 64'd0);
        chk("reset frame_err", 64'(frame_err), 64'd0);
        chk("reset overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        idle(4);

        // Vector table: plain words, each acknowledged.
        for (int v = 0; v < 4; v++) begin
            send_byte(vecs[v].b0, 1'b1, -1);
            send_byte(vecs[v].b1, 1'b1, -1);
            send_byte(vecs[v].b2, 1'b1, -1);
            send_byte(vecs[v].b3, 1'b1, -1);
            exp_q.push_back(vecs[v].exp);
            wait_ready($sformatf("vec%0d ready", v));
            check_sb($sformatf("vec%0d data", v));
            do_ack($sformatf("vec%0d ack drop", v));
        end

        // Short low glitch while idle must not start a byte.
        f0 = ferr_seen;
        RX = 1'b0;
        repeat (8) @(negedge clk);
        idle(3 * CPB);
        chk("glitch ready_op", 64'(ready_op), 64'd0);
        chk("glitch frame_err", 64'(ferr_seen - f0), 64'd0);
        chk("glitch overrun", 64'(overrun), 64'd0);
        send_word(32'h0BADF00D);
        exp_q.push_back(32'h0BADF00D);
        wait_ready("post-glitch ready");
        check_sb("post-glitch data");
        do_ack("post-glitch ack");

        // Bad stop bit on byte 0, then a good word.
        f0 = ferr_seen;
        send_byte(8'hAA, 1'b0, -1);
        idle(CPB);
        chk("ferr byte0 pulse count", 64'(ferr_seen - f0), 64'd1);
        chk("ferr byte0 no ready", 64'(ready_op), 64'd0);
        send_word(32'h04030201);
        exp_q.push_back(32'h04030201);
        wait_ready("ferr byte0 ready");
        check_sb("ferr byte0 data");
        do_ack("ferr byte0 ack");

        // Bad stop bit on byte 1 discards the partial word.
        f0 = ferr_seen;
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b0, -1);
        idle(CPB);
        chk("ferr byte1 pulse count", 64'(ferr_seen - f0), 64'd1);
        send_word(32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        wait_ready("ferr byte1 ready");
        check_sb("ferr byte1 data");
        do_ack("ferr byte1 ack");

        // Overrun: second word arrives with the first still unacknowledged.
        send_word(32'hA1B2C3D4);
        exp_q.push_back(32'hA1B2C3D4);
        send_word(32'h55667788);
        chk("overrun ready", 64'(ready_op), 64'd1);
        check_sb("overrun data held");
        chk("overrun flag", 64'(overrun), 64'd1);
        do_ack("overrun ack drop");
        chk("overrun cleared", 64'(overrun), 64'd0);

        // Ack lands in the same cycle as the second word's last stop sample.
        send_word(32'h13579BDF);
        exp_q.push_back(32'h13579BDF);
        wait_ready("coinc first ready");
        check_sb("coinc first data");
        send_byte(8'h10, 1'b1, -1);
        send_byte(8'h32, 1'b1, -1);
        send_byte(8'h54, 1'b1, -1);
        send_byte(8'h76, 1'b1, 10);
        exp_q.push_back(32'h76543210);
        chk("coinc ready stays", 64'(ready_op), 64'd1);
        check_sb("coinc second data");
        chk("coinc no overrun", 64'(overrun), 64'd0);
        do_ack("coinc ack");

        // Reset in the middle of a word with a word pending.
        send_word(32'h2468ACE0);
        exp_q.push_back(32'h2468ACE0);
        wait_ready("pre-reset ready");
        check_sb("pre-reset data");
        send_byte(8'h99, 1'b1, -1);
        send_byte(8'h88, 1'b1, -1);
        RX = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midword reset data_out", 64'(data_out), 64'd0);
        chk("midword reset ready_op", 64'(ready_op), 64'd0);
        RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(CPB);
        send_word(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        wait_ready("post-reset ready");
        check_sb("post-reset data");
        do_ack("post-reset ack");

`ifdef UART_RX_TIMEOUT_EN
        // Partial word abandoned by the idle timeout.
        send_byte(8'hAA, 1'b1, -1);
        send_byte(8'hBB, 1'b1, -1);
        idle(25 * CPB);
        send_word(32'h89ABCDEF);
        exp_q.push_back(32'h89ABCDEF);
        wait_ready("timeout ready");
        check_sb("timeout data");
        do_ack("timeout ack");
`endif

        chk("frame_err pulse width", 64'(ferr_wide), 64'd0);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Upstream operand source for the CORDIC/FPU test path. Replaces the fixed ROM with live operands received over the serial line.
- Receives 8N1 UART bytes on RX and assembles NB = W/8 consecutive bytes into one W-bit word, least significant byte first. Byte 0 lands in [7:0], matching the transmit-side byte order.
- Presents the assembled word to the operation FSM with a level ready/ack handshake.

Parameters:
- W, 32, word width; must be 32 or 64 (NB = 4 or 8).
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); minimum 4.
- TIMEOUT_BITS, 20, idle bit periods before a partial word is discarded (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low; all state clears while low
- RX  in  1  serial input, idle high, asynchronous to clk
- ack_op  in  1  consumer has taken data_out
- data_out  out  W  assembled word, stable while ready_op=1
- ready_op  out  1  word valid, level
- frame_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  sticky, a complete word was dropped

Behaviour:
- Reset values: data_out=0, ready_op=0, frame_err=0, overrun=0, byte count=0, bit FSM in IDLE, synchroniser flops=1.
- RX input: passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synced RX=0, load counter with CLKS_PER_BIT/2 - 1 and go to START.
  - START: when the counter expires, sample RX. If 0, go to DATA with bit index 0 and counter CLKS_PER_BIT-1. If 1 (glitch), return to IDLE with no side effects.
  - DATA: sample at each counter expiry and shift in LSB first. After bit 7, go to STOP.
  - STOP: at expiry, sample RX.
    - 1: byte complete; goes to the assembler; FSM returns to IDLE.
    - 0: frame_err pulses for 1 cycle, the byte is discarded, byte count resets to 0, and the FSM waits in STOP until RX=1 before returning to IDLE.
- Word assembler:
  - Byte k is written into word bits [8k+7:8k]; byte count increments.
  - On byte NB-1, the word transfers to data_out and ready_op=1 in the cycle after the stop-bit sample. Byte count wraps to 0.
  - Latency: ready_op rises 1 clk after the last stop-bit sample.
- Handshake:
  - ack_op=1 while ready_op=1: ready_op=0 next cycle; overrun clears.
  - ack_op while ready_op=0 is ignored.
- Boundary cases:
  - Word completes while ready_op=1 and no ack_op: new word dropped, data_out unchanged, overrun=1.
  - Word completes in the same cycle as ack_op: new word loads, ready_op stays 1, no overrun.
  - Frame error on byte k>0: the partial word is discarded; the next good byte becomes byte 0.
  - rst low mid-byte or mid-word: immediate return to reset values. A byte in flight is lost, and the next falling edge after release starts a fresh frame.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while byte count != 0 and the FSM is in IDLE. It clears on every start-bit detection.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT, byte count resets to 0 and the partial word is discarded. No flag is raised.
- Undefined: no counter is built; a partial word waits indefinitely for its remaining bytes.

Decomposition:
- Package uart_rx_pkg: bit-FSM state enum (IDLE, START, DATA, STOP); localparams NB=W/8 and counter width $clog2(CLKS_PER_BIT).
- Sub-module uart_rx_byte: synchroniser plus bit FSM. Outputs byte[7:0], byte_valid pulse and frame_err.
- Top uart_rx_word: word assembler, handshake, overrun and optional timeout.

Test Plan (CLKS_PER_BIT=16, W=32):
- Bytes 0x78,0x56,0x34,0x12 -> ready_op=1 with data_out=0x12345678; ack_op for 1 cycle -> ready_op=0 next cycle.
- 8-cycle low glitch on RX while idle -> no byte accepted, byte count stays 0, no flags.
- Byte 0xAA with stop bit driven 0, then 4 good bytes 0x01..0x04 -> frame_err 1-cycle pulse; data_out=0x04030201.
- Two full words, no ack_op after the first -> data_out holds the first word, overrun=1; ack_op -> overrun=0.
- Second word's last stop sample coincides with ack_op of the first -> data_out=second word, ready_op stays 1, overrun=0.
- rst low after 2 bytes, release, send 4 bytes 0xEF,0xBE,0xAD,0xDE -> data_out=0xDEADBEEF. With UART_RX_TIMEOUT_EN: 2 bytes, 25 idle bit periods, 4 bytes -> data_out equals the last 4 bytes.
